// File: rtl/spi_slave_receiver.sv
// rtl/spi_slave_receiver.sv - Mode-0 SPI slave word receiver with one-word-delayed echo
//
// Purpose:
//   Samples already-synchronized SPI pins in the clk domain, detects sclk
//   edges, assembles MSB-first words and reports them as parallel data.
//   Frame boundaries (cs_n edges) and truncated words are flagged. Each
//   completed word is echoed on miso during the following word slot.
//
// Ports:
//   clk          system clock, all logic on the rising edge
//   reset_n      asynchronous active-low reset
//   sclk         SPI clock (synchronized)
//   mosi         SPI data in (synchronized, same depth as sclk)
//   cs_n         SPI chip select, active low (synchronized, same depth)
//   miso         SPI data out, forced 0 while cs_n is high
//   data_out     last completed word, held until the next one
//   data_valid   one-cycle pulse, data_out is new
//   first_word   with data_valid, word is the first of its frame
//   frame_done   one-cycle pulse after cs_n rises
//   frame_error  with frame_done, cs_n rose in the middle of a word
//   busy         registered copy of ~cs_n

module spi_slave_receiver #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  sclk,
  input  logic                  mosi,
  input  logic                  cs_n,
  output logic                  miso,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  first_word,
  output logic                  frame_done,
  output logic                  frame_error,
  output logic                  busy
);

  localparam int CNT_W = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  logic                  sclk_prev;
  logic                  cs_prev;
  logic [CNT_W-1:0]      bit_cnt;
  logic [DATA_WIDTH-1:0] rx_shift;
  logic [DATA_WIDTH-1:0] tx_shift;
  logic [DATA_WIDTH-1:0] echo_word;
  logic                  first_pending;
  // armed: cs_n has been seen high since reset. cs_prev resets to 1 so that an
  // idle-high cs_n does not fake a frame end, but that alone would turn a cs_n
  // held low across reset into a frame start; armed suppresses that case.
  logic                  armed;
  // in_frame: a genuine frame start has been seen and cs_n has not risen yet.
  // Bits are only collected inside a frame that was properly opened.
  logic                  in_frame;

  logic                  sclk_rise;
  logic                  sclk_fall;
  logic                  frame_start;
  logic                  frame_end;
  logic [DATA_WIDTH-1:0] rx_next;

  assign sclk_rise   = sclk & ~sclk_prev;
  assign sclk_fall   = ~sclk & sclk_prev;
  assign frame_start = ~cs_n & cs_prev & armed;
  assign frame_end   = cs_n & ~cs_prev;
  assign rx_next     = {rx_shift[DATA_WIDTH-2:0], mosi};

  // Host samples miso on its rising edge; tx_shift is updated one clk after
  // each fall, long before the next rise given the minimum phase length.
  assign miso = ~cs_n & tx_shift[DATA_WIDTH-1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sclk_prev     <= 1'b0;
      cs_prev       <= 1'b1;
      bit_cnt       <= '0;
      rx_shift      <= '0;
      tx_shift      <= '0;
      echo_word     <= '0;
      first_pending <= 1'b0;
      armed         <= 1'b0;
      in_frame      <= 1'b0;
      data_out      <= '0;
      data_valid    <= 1'b0;
      first_word    <= 1'b0;
      frame_done    <= 1'b0;
      frame_error   <= 1'b0;
      busy          <= 1'b0;
    end else begin
      sclk_prev   <= sclk;
      cs_prev     <= cs_n;
      busy        <= ~cs_n;
      data_valid  <= 1'b0;
      frame_done  <= 1'b0;
      frame_error <= 1'b0;

      if (cs_n) begin
        armed <= 1'b1;
      end

      if (frame_start) begin
        bit_cnt       <= '0;
        rx_shift      <= '0;
        first_pending <= 1'b1;
        in_frame      <= 1'b1;
        // The first word slot of a frame echoes the previous frame's last word.
        tx_shift      <= echo_word;
      end else if (frame_end) begin
        // A cs_n rise wins over a coincident sclk rise: the partial word is
        // dropped and reported through frame_error.
        frame_done  <= 1'b1;
        frame_error <= (bit_cnt != '0);
        bit_cnt     <= '0;
        rx_shift    <= '0;
        in_frame    <= 1'b0;
      end else if (!cs_n && in_frame) begin
        if (sclk_rise) begin
          rx_shift <= rx_next;
          if (bit_cnt == LAST_BIT) begin
            bit_cnt       <= '0;
            data_out      <= rx_next;
            echo_word     <= rx_next;
            data_valid    <= 1'b1;
            first_word    <= first_pending;
            first_pending <= 1'b0;
          end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end

        if (sclk_fall) begin
          // bit_cnt == 0 on a fall means a word has just completed (or none
          // has been clocked yet), so start driving the word to be echoed.
          if (bit_cnt == '0) begin
            tx_shift <= echo_word;
          end else begin
            tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_receiver.sv
// tb/tb_spi_slave_receiver.sv - directed table-driven bench for spi_slave_receiver

module tb_spi_slave_receiver;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          sclk;
  logic          mosi;
  logic          cs_n;
  logic          miso;
  logic [DW-1:0] data_out;
  logic          data_valid;
  logic          first_word;
  logic          frame_done;
  logic          frame_error;
  logic          busy;

  always #5 clk = ~clk;

  spi_slave_receiver #(.DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .sclk       (sclk),
    .mosi       (mosi),
    .cs_n       (cs_n),
    .miso       (miso),
    .data_out   (data_out),
    .data_valid (data_valid),
    .first_word (first_word),
    .frame_done (frame_done),
    .frame_error(frame_error),
    .busy       (busy)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Event capture from the output pulses, sampled on the falling edge.
  int            valid_cnt = 0;
  int            done_cnt  = 0;
  logic [DW-1:0] got_data [4];
  logic          got_first[4];
  logic          got_err = 1'b0;

  always @(negedge clk) begin
    if (data_valid) begin
      if (valid_cnt < 4) begin
        got_data[valid_cnt]  = data_out;
        got_first[valid_cnt] = first_word;
      end
      valid_cnt = valid_cnt + 1;
    end
    if (frame_done) begin
      got_err  = frame_error;
      done_cnt = done_cnt + 1;
    end
  end

  typedef struct {
    logic [15:0] bits;
    int          nbits;
    int          exp_nvalid;
    logic [7:0]  exp_d0;
    logic [7:0]  exp_d1;
    logic        exp_f0;
    logic        exp_f1;
    logic [15:0] exp_miso;
    logic        exp_err;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clk_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_events();
    valid_cnt = 0;
    done_cnt  = 0;
    got_err   = 1'b0;
  endtask

  // Host-side mode-0 shifting: mosi set during the low phase, miso sampled
  // just before the rising edge.
  task automatic send_bits(input logic [15:0] bits, input int n, output logic [15:0] cap);
    cap = '0;
    for (int i = n - 1; i >= 0; i--) begin
      mosi = bits[i];
      clk_n(4);
      cap  = {cap[14:0], miso};
      sclk = 1'b1;
      clk_n(4);
      sclk = 1'b0;
    end
  endtask

  task automatic run_frame(input logic [15:0] bits, input int n, output logic [15:0] cap);
    cs_n = 1'b0;
    clk_n(4);
    send_bits(bits, n, cap);
    clk_n(4);
    cs_n = 1'b1;
    clk_n(6);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] cap;
    int          idle_bad;

    vecs[0] = '{16'hA53C, 16, 2, 8'hA5, 8'h3C, 1'b1, 1'b0, 16'h00A5, 1'b0};
    vecs[1] = '{16'h00FF,  8, 1, 8'hFF, 8'h00, 1'b1, 1'b0, 16'h003C, 1'b0};
    vecs[2] = '{16'h0016,  5, 0, 8'h00, 8'h00, 1'b0, 1'b0, 16'h001F, 1'b1};
    vecs[3] = '{16'h0081,  8, 1, 8'h81, 8'h00, 1'b1, 1'b0, 16'h00FF, 1'b0};

    reset_n = 1'b0;
    sclk    = 1'b0;
    mosi    = 1'b0;
    cs_n    = 1'b1;
    clk_n(3);
    check("reset data_out", data_out, 8'h00);
    check("reset flags", {data_valid, first_word, frame_done, frame_error, busy, miso}, 6'b0);
    reset_n = 1'b1;
    clk_n(2);
    clear_events();

    // Idle: cs_n high, sclk and mosi toggling must be ignored.
    idle_bad = 0;
    for (int i = 0; i < 10; i++) begin
      mosi = i[0];
      clk_n(3);
      sclk = ~sclk;
      if (miso !== 1'b0 || busy !== 1'b0) idle_bad = idle_bad + 1;
    end
    sclk = 1'b0;
    clk_n(4);
    check("idle miso/busy", idle_bad, 0);
    check("idle data_valid", valid_cnt, 0);
    check("idle frame_done", done_cnt, 0);

    for (int v = 0; v < 4; v++) begin
      clear_events();
      run_frame(vecs[v].bits, vecs[v].nbits, cap);
      check($sformatf("v%0d nvalid", v), valid_cnt, vecs[v].exp_nvalid);
      if (vecs[v].exp_nvalid > 0) begin
        check($sformatf("v%0d word0", v), got_data[0], vecs[v].exp_d0);
        check($sformatf("v%0d first0", v), got_first[0], vecs[v].exp_f0);
      end
      if (vecs[v].exp_nvalid > 1) begin
        check($sformatf("v%0d word1", v), got_data[1], vecs[v].exp_d1);
        check($sformatf("v%0d first1", v), got_first[1], vecs[v].exp_f1);
      end
      check($sformatf("v%0d miso", v), cap, vecs[v].exp_miso);
      check($sformatf("v%0d frame_done", v), done_cnt, 1);
      check($sformatf("v%0d frame_error", v), got_err, vecs[v].exp_err);
      check($sformatf("v%0d busy idle", v), busy, 1'b0);
    end

    // cs_n rises in the same cycle as the 8th sclk rise.
    clear_events();
    cs_n = 1'b0;
    clk_n(4);
    send_bits(16'h002A, 7, cap);
    mosi = 1'b1;
    clk_n(4);
    sclk = 1'b1;
    cs_n = 1'b1;
    clk_n(4);
    sclk = 1'b0;
    clk_n(4);
    check("race nvalid", valid_cnt, 0);
    check("race frame_done", done_cnt, 1);
    check("race frame_error", got_err, 1'b1);
    check("race data_out held", data_out, 8'h81);

    // Reset asserted mid-byte, cs_n held low across and after it.
    clear_events();
    cs_n = 1'b0;
    clk_n(4);
    send_bits(16'h000A, 4, cap);
    clk_n(2);
    check("pre-reset busy", busy, 1'b1);
    reset_n = 1'b0;
    #1;
    check("async reset data_out", data_out, 8'h00);
    check("async reset flags", {data_valid, first_word, frame_done, frame_error, busy, miso}, 6'b0);
    clk_n(2);
    reset_n = 1'b1;
    clear_events();
    send_bits(16'h00C3, 8, cap);
    clk_n(4);
    check("post-reset nvalid", valid_cnt, 0);
    check("post-reset busy", busy, 1'b1);
    check("post-reset miso", cap, 16'h0000);
    cs_n = 1'b1;
    clk_n(6);
    clear_events();
    run_frame(16'h005A, 8, cap);
    check("rearm nvalid", valid_cnt, 1);
    check("rearm word", got_data[0], 8'h5A);
    check("rearm first", got_first[0], 1'b1);
    check("rearm miso", cap, 16'h0000);
    check("rearm frame_done", done_cnt, 1);
    check("rearm frame_error", got_err, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
